// File: rtl/neuron_output_stage.sv
// neuron_output_stage
//   Requantizes completed MAC sums into signed OUT_W-bit activations.
//   Stage 1 registers sat(acc_in + bias). Stage 2 is combinational on that register:
//   it rounds half up, arithmetic-shifts right by SHIFT, optionally applies ReLU,
//   and saturates. Results queue in a FIFO_DEPTH-entry FIFO and leave over valid/ready.
// Ports
//   clk, reset              clock; synchronous active-high reset
//   acc_in, bias            signed sum and bias, taken when acc_valid && acc_ready
//   acc_valid / acc_ready   input handshake; ready is derived from registered credit only
//   out_data / out_sat      FIFO-head activation and its saturation flag
//   out_valid / out_ready   output handshake
//   clr_stats, sat_count    clear / saturating count of saturated results
module neuron_output_stage #(
  parameter int ACC_W      = 16,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = 4,
  parameter int RELU_EN    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] acc_in,
  input  logic [ACC_W-1:0] bias,
  input  logic             acc_valid,
  output logic             acc_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  input  logic             clr_stats,
  output logic [7:0]       sat_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [ACC_W:0]   RND     = (ACC_W+1)'(1) << (SHIFT - 1);

  // Stage 1 registers
  logic             s1_v_q;
  logic [ACC_W-1:0] s1_q;
  logic             s1_sat_q;

  // FIFO state
  logic [OUT_W:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       sat_count_q, sat_count_d;

  // Bias add in ACC_W+1 bits, then clamp back to ACC_W
  logic [ACC_W:0]   sum_w;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_sat;

  // Stage 2 datapath
  logic [ACC_W:0]        rsum;
  logic signed [ACC_W:0] shifted;
  logic [ACC_W:0]        relu_v;
  logic                  out_ovf;
  logic [OUT_W-1:0]      res;
  logic                  res_sat;

  logic accept, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign acc_ready = !reset && ((int'(s1_v_q) + int'(count_q)) < FIFO_DEPTH);
  assign accept    = acc_valid && acc_ready;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = s1_v_q;

  assign out_data  = out_valid ? mem_q[rd_ptr_q][OUT_W-1:0] : '0;
  assign out_sat   = out_valid ? mem_q[rd_ptr_q][OUT_W]     : 1'b0;
  assign sat_count = sat_count_q;

  always_comb begin
    sum_w   = {acc_in[ACC_W-1], acc_in} + {bias[ACC_W-1], bias};
    // Overflow shows up as the two top bits disagreeing
    sum_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    sum_sat = sum_ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];
  end

  always_comb begin
    // Cannot overflow: max positive S1 plus the rounding constant stays below 2^ACC_W
    rsum    = {s1_q[ACC_W-1], s1_q} + RND;
    shifted = $signed(rsum) >>> SHIFT;
    relu_v  = shifted;
    if ((RELU_EN != 0) && shifted[ACC_W]) begin
      relu_v = '0;
    end
    // In range only when bits [ACC_W:OUT_W-1] are a pure sign extension
    out_ovf = !((&relu_v[ACC_W:OUT_W-1]) || !(|relu_v[ACC_W:OUT_W-1]));
    res     = out_ovf ? (relu_v[ACC_W] ? OUT_MIN : OUT_MAX) : relu_v[OUT_W-1:0];
    res_sat = out_ovf || s1_sat_q;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    sat_count_d = sat_count_q;
    if (clr_stats) begin
      sat_count_d = '0;
    end else if (push && res_sat && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q      <= 1'b0;
      s1_sat_q    <= 1'b0;
      s1_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sat_count_q <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_q     <= sum_sat;
        s1_sat_q <= sum_ovf;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= {res_sat, res};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q     <= count_d;
      sat_count_q <= sat_count_d;
    end
  end

endmodule

// File: tb/tb_neuron_output_stage.sv
// tb_neuron_output_stage
//   Directed bench for neuron_output_stage. Two instances share all stimulus:
//   u_relu (RELU_EN=1) and u_lin (RELU_EN=0). A negedge monitor keeps a scoreboard
//   of expected {sat, data} per instance and compares every popped result.
module tb_neuron_output_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] acc_in, bias;
  logic        acc_valid, out_ready, clr_stats;
  logic        acc_ready_r, acc_ready_l;
  logic [7:0]  out_data_r, out_data_l;
  logic        out_valid_r, out_valid_l, out_sat_r, out_sat_l;
  logic [7:0]  sat_count_r, sat_count_l;

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0;
  int s_idx, stalls, p0;
  int stim_a[32], stim_b[32];
  logic [8:0] q_r[$], q_l[$];

  always #5 clk = ~clk;

  neuron_output_stage #(.ACC_W(16), .OUT_W(8), .SHIFT(4), .RELU_EN(1), .FIFO_DEPTH(4)) u_relu (
    .clk(clk), .reset(reset), .acc_in(acc_in), .bias(bias), .acc_valid(acc_valid),
    .acc_ready(acc_ready_r), .out_data(out_data_r), .out_valid(out_valid_r),
    .out_ready(out_ready), .out_sat(out_sat_r), .clr_stats(clr_stats), .sat_count(sat_count_r)
  );

  neuron_output_stage #(.ACC_W(16), .OUT_W(8), .SHIFT(4), .RELU_EN(0), .FIFO_DEPTH(4)) u_lin (
    .clk(clk), .reset(reset), .acc_in(acc_in), .bias(bias), .acc_valid(acc_valid),
    .acc_ready(acc_ready_l), .out_data(out_data_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_sat(out_sat_l), .clr_stats(clr_stats), .sat_count(sat_count_l)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Integer reference: saturating add, floor((s + 8) / 16), optional ReLU, clamp to 8 bits
  function automatic logic [8:0] model(input int a, input int b, input bit relu);
    int s, r;
    bit st;
    st = 1'b0;
    s  = a + b;
    if (s > 32767)  begin s = 32767;  st = 1'b1; end
    if (s < -32768) begin s = -32768; st = 1'b1; end
    r = (s + 8) >>> 4;
    if (relu && r < 0) r = 0;
    if (r > 127)  begin r = 127;  st = 1'b1; end
    if (r < -128) begin r = -128; st = 1'b1; end
    model = {st, 8'(r)};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid_r && out_ready) begin
        if (q_r.size() == 0) check("sb_relu_underflow", 1, 0);
        else check("sb_relu", {out_sat_r, out_data_r}, q_r.pop_front());
        pop_cnt++;
      end
      if (out_valid_l && out_ready) begin
        if (q_l.size() == 0) check("sb_lin_underflow", 1, 0);
        else check("sb_lin", {out_sat_l, out_data_l}, q_l.pop_front());
      end
      if (acc_valid && acc_ready_r) begin
        q_r.push_back(model($signed(acc_in), $signed(bias), 1'b1));
        q_l.push_back(model($signed(acc_in), $signed(bias), 1'b0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sum for one cycle, then two edges: accept, then push into the FIFO
  task automatic send(input int a, input int b);
    check("send_ready", acc_ready_r, 1);
    acc_in = 16'(a); bias = 16'(b); acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    tick();
  endtask

  // mode 0: out_ready low, 1: high, 2: toggling 1010
  task automatic run_stream(input int n, input int mode, input int max_cyc);
    logic hs;
    for (int c = 0; c < max_cyc && s_idx < n; c++) begin
      out_ready = (mode == 1) || (mode == 2 && (c % 2) == 0);
      acc_valid = 1'b1;
      acc_in    = 16'(stim_a[s_idx]);
      bias      = 16'(stim_b[s_idx]);
      @(negedge clk);
      hs = acc_ready_r;
      if (!hs) stalls++;
      tick();
      if (hs) s_idx++;
    end
    acc_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; acc_valid = 1'b0; acc_in = '0; bias = '0; out_ready = 1'b1; clr_stats = 1'b0;
    tick(); tick();
    check("rst_ready", acc_ready_r, 0);
    check("rst_valid", out_valid_r, 0);
    check("rst_data", out_data_r, 0);
    check("rst_sat", out_sat_r, 0);
    check("rst_satcnt", sat_count_r, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", acc_ready_r, 1);

    // 1: latency and basic rounding
    acc_in = 16'd256; bias = 16'd16; acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    check("lat_valid_k", out_valid_r, 0);
    tick();
    check("lat_valid_k1", out_valid_r, 1);
    check("t1_data", $signed(out_data_r), 17);
    check("t1_sat", out_sat_r, 0);
    tick(); tick();

    // 2: negative sum, ReLU vs pass-through
    send(-100, 0);
    check("t2_relu", $signed(out_data_r), 0);
    check("t2_lin", $signed(out_data_l), -6);
    tick(); tick();

    // 3: bias-add and output saturation
    send(32767, 32767);
    check("t3_pos_data", $signed(out_data_r), 127);
    check("t3_pos_sat", out_sat_r, 1);
    check("t3_satcnt", sat_count_r, 1);
    tick(); tick();
    send(-32768, -1);
    check("t3_neg_lin", $signed(out_data_l), -128);
    check("t3_neg_lin_sat", out_sat_l, 1);
    check("t3_neg_relu", $signed(out_data_r), 0);
    check("t3_neg_relu_sat", out_sat_r, 1);
    check("t3_satcnt2", sat_count_l, 2);
    tick(); tick();

    // 4: backpressure and credit limit
    for (int i = 0; i < 6; i++) begin stim_a[i] = 16 * (i + 1); stim_b[i] = 0; end
    s_idx = 0; p0 = pop_cnt;
    run_stream(6, 0, 8);
    check("t4_accepted", s_idx, 4);
    check("t4_ready_low", acc_ready_r, 0);
    check("t4_head", $signed(out_data_r), 1);
    run_stream(6, 1, 20);
    check("t4_all_in", s_idx, 6);
    out_ready = 1'b1;
    repeat (8) tick();
    check("t4_pops", pop_cnt - p0, 6);

    // 5: full-rate streaming, then toggling out_ready
    for (int i = 0; i < 20; i++) begin stim_a[i] = i * 1900 - 20000; stim_b[i] = i * 7 - 50; end
    s_idx = 0; stalls = 0; p0 = pop_cnt;
    run_stream(20, 1, 20);
    check("t5_accepted", s_idx, 20);
    check("t5_stalls", stalls, 0);
    tick(); tick();
    check("t5_pops", pop_cnt - p0, 20);
    for (int i = 0; i < 20; i++) begin stim_a[i] = 25000 - i * 2600; stim_b[i] = 3 * i; end
    s_idx = 0; p0 = pop_cnt;
    run_stream(20, 2, 80);
    check("t5t_accepted", s_idx, 20);
    out_ready = 1'b1;
    repeat (8) tick();
    check("t5t_pops", pop_cnt - p0, 20);
    check("t5t_drained", q_r.size(), 0);

    // clr_stats on the same edge as a saturated push wins
    acc_in = 16'd32767; bias = 16'd32767; acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0; clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_vs_push", sat_count_r, 0);
    tick(); tick();

    // sat_count sticks at 255
    acc_in = 16'd32767; bias = 16'd32767; acc_valid = 1'b1;
    repeat (260) tick();
    acc_valid = 1'b0;
    repeat (4) tick();
    check("satcnt_hold", sat_count_r, 255);

    // 6: reset with 3 queued entries and S1 full
    for (int i = 0; i < 4; i++) begin stim_a[i] = 32767; stim_b[i] = 100; end
    s_idx = 0;
    run_stream(4, 0, 6);
    check("t6_accepted", s_idx, 4);
    check("t6_valid_pre", out_valid_r, 1);
    reset = 1'b1;
    #1;
    check("t6_ready_in_rst", acc_ready_r, 0);
    tick();
    check("t6_valid", out_valid_r, 0);
    check("t6_satcnt", sat_count_r, 0);
    check("t6_satcnt_lin", sat_count_l, 0);
    q_r.delete(); q_l.delete();
    reset = 1'b0; out_ready = 1'b1;
    tick();
    send(160, 0);
    check("t6_data", $signed(out_data_r), 10);
    tick(); tick();
    check("t6_drained", q_r.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
